fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 128 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Pulls words from a registered-read FIFO into a 3-entry output buffer and
// presents them as a ready/valid stream framed into packets of pkt_len words.
module fifo_stream_reader #(
  parameter int DSIZE = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  input  logic             run,
  input  logic [LEN_W-1:0] pkt_len,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             pkt_done
);

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [DSIZE-1:0] buf_q [3];
  logic [DSIZE-1:0] buf_d [3];
  logic [1:0]       head_q, head_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             inflight_q, inflight_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             pkt_done_q, pkt_done_d;

  logic             rd_go;
  logic             vld;
  logic             last;
  logic             hs;
  logic [LEN_W-1:0] pkt_len_eff;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    wrap3 = (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Reads are credited against buffer slots, counting the one still in flight.
  always_comb begin
    rd_go       = !rst && !fifo_rempty && run &&
                  (({1'b0, cnt_q} + {2'b0, inflight_q}) < 3'd3);
    vld         = !rst && (cnt_q != 2'd0);
    pkt_len_eff = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
    if (state_q == IDLE) last = vld && (pkt_len_eff == LEN_W'(1));
    else                 last = vld && (beat_q == len_q - LEN_W'(1));
    hs          = vld && m_tready;
  end

  assign fifo_rinc = rd_go;
  assign m_tvalid  = vld;
  assign m_tdata   = vld ? buf_q[head_q] : '0;
  assign m_tlast   = last;
  assign pkt_done  = !rst && pkt_done_q;

  // Buffer: the tail slot is derived from the pre-pop head, so push and pop
  // in the same cycle never collide.
  always_comb begin
    buf_d      = buf_q;
    head_d     = head_q;
    cnt_d      = cnt_q;
    inflight_d = rd_go;
    if (inflight_q) buf_d[wrap3({1'b0, head_q} + {1'b0, cnt_q})] = fifo_rdata;
    if (hs) head_d = wrap3({1'b0, head_q} + 3'd1);
    case ({inflight_q, hs})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_d     = beat_q;
    pkt_done_d = hs && last;
    case (state_q)
      IDLE: begin
        if (hs && !last) begin
          state_d = IN_PKT;
          len_d   = pkt_len_eff;
          beat_d  = LEN_W'(1);
        end
      end
      IN_PKT: begin
        if (hs) begin
          if (last) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      head_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      len_q      <= '0;
      beat_q     <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // Data slots need no reset: occupancy gates their visibility.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: FIFO model feeds the DUT, a scoreboard
// queue of expected (data, last) pairs is consumed on each stream handshake.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fifo_rdata = '0;
  logic        fifo_rempty;
  logic        fifo_rinc;
  logic        run;
  logic [15:0] pkt_len;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        pkt_done;

  fifo_stream_reader #(.DSIZE(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
    .run(run), .pkt_len(pkt_len),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model with registered read data.
  logic [31:0] fmem [0:255];
  int unsigned fwr = 0;
  int unsigned frd = 0;
  assign fifo_rempty = (fwr == frd);

  always @(posedge clk) begin
    if (rst) frd <= fwr;
    else if (fifo_rinc && fwr != frd) begin
      fifo_rdata <= fmem[frd[7:0]];
      frd        <= frd + 1;
    end
  end

  // Scoreboard and bookkeeping, all owned by the initial block.
  logic [31:0] exp_d [0:255];
  logic        exp_l [0:255];
  int unsigned ew = 0, er = 0;
  int checks = 0, passed = 0;
  int cyc = 0, rinc_cnt = 0, done_cnt = 0, case_beats = 0;
  int first_rinc = -1, first_valid = -1, first_beat = -1, last_beat = -1;
  logic        prev_stall = 1'b0, prev_l = 1'b0, prev_lhs = 1'b0;
  logic [31:0] prev_d = '0;
  logic        toggle_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    fmem[fwr[7:0]]  = d;
    fwr             = fwr + 1;
    exp_d[ew[7:0]]  = d;
    exp_l[ew[7:0]]  = l;
    ew              = ew + 1;
  endtask

  task automatic mon();
    logic hs;
    cyc++;
    if (rst) begin
      er = ew; prev_stall = 0; prev_lhs = 0;
      return;
    end
    if (fifo_rinc) begin
      rinc_cnt++;
      if (first_rinc < 0) first_rinc = cyc;
      check("rinc_while_empty", {63'b0, fifo_rempty}, 64'd0);
    end
    if (m_tvalid && first_valid < 0) first_valid = cyc;
    check("pkt_done", {63'b0, pkt_done}, {63'b0, prev_lhs});
    if (pkt_done) done_cnt++;
    if (prev_stall) begin
      check("stall_valid", {63'b0, m_tvalid}, 64'd1);
      check("stall_data", {32'b0, m_tdata}, {32'b0, prev_d});
      check("stall_last", {63'b0, m_tlast}, {63'b0, prev_l});
    end
    hs = m_tvalid && m_tready;
    if (hs) begin
      if (er == ew) check("extra_beat", 64'd1, 64'd0);
      else begin
        check("beat_data", {32'b0, m_tdata}, {32'b0, exp_d[er[7:0]]});
        check("beat_last", {63'b0, m_tlast}, {63'b0, exp_l[er[7:0]]});
        er = er + 1;
      end
      case_beats++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
    end
    prev_stall = m_tvalid && !m_tready;
    prev_d     = m_tdata;
    prev_l     = m_tlast;
    prev_lhs   = hs && m_tlast;
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (toggle_rdy) m_tready = ~m_tready;
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while (!(er == ew && fwr == frd && !m_tvalid) && n < maxc) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, {63'b0, (n < maxc)}, 64'd1);
    step();
    step();
  endtask

  task automatic new_case();
    done_cnt = 0; case_beats = 0; rinc_cnt = 0;
    first_rinc = -1; first_valid = -1; first_beat = -1; last_beat = -1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; pkt_len = 16'd4; m_tready = 1'b0;
    step();
    step();
    check("rst_rinc",  {63'b0, fifo_rinc}, 64'd0);
    check("rst_valid", {63'b0, m_tvalid},  64'd0);
    check("rst_last",  {63'b0, m_tlast},   64'd0);
    check("rst_done",  {63'b0, pkt_done},  64'd0);
    check("rst_data",  {32'b0, m_tdata},   64'd0);
    rst = 1'b0;
    step();
    check("post_rst_valid", {63'b0, m_tvalid}, 64'd0);

    // Case 1: two 4-word packets at full rate.
    new_case();
    pkt_len = 16'd4; m_tready = 1'b1; run = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'h10 + i, (i % 4) == 3);
    drain("c1", 60);
    check("c1_beats",   case_beats, 8);
    check("c1_done",    done_cnt, 2);
    check("c1_latency", first_valid - first_rinc, 2);
    check("c1_span",    last_beat - first_beat, 7);

    // Case 2: ready toggles every cycle.
    new_case();
    pkt_len = 16'd6; toggle_rdy = 1'b1;
    for (int i = 0; i < 6; i++) push_word(32'h20 + i, i == 5);
    drain("c2", 80);
    toggle_rdy = 1'b0; m_tready = 1'b1;
    check("c2_beats", case_beats, 6);
    check("c2_done",  done_cnt, 1);

    // Case 3: zero length is a 1-word packet, as is length 1.
    new_case();
    pkt_len = 16'd0;
    for (int i = 0; i < 3; i++) push_word(32'h30 + i, 1'b1);
    drain("c3a", 40);
    check("c3a_done", done_cnt, 3);
    new_case();
    pkt_len = 16'd1;
    for (int i = 0; i < 3; i++) push_word(32'h38 + i, 1'b1);
    drain("c3b", 40);
    check("c3b_done", done_cnt, 3);

    // Case 4: pkt_len changes mid-packet; the change applies to the next one.
    new_case();
    pkt_len = 16'd5;
    for (int i = 0; i < 7; i++) push_word(32'h40 + i, (i == 4) || (i == 6));
    for (int n = 0; n < 60 && !(er == ew && fwr == frd && !m_tvalid); n++) begin
      if (case_beats >= 2) pkt_len = 16'd2;
      step();
    end
    step();
    step();
    check("c4_beats", case_beats, 7);
    check("c4_done",  done_cnt, 2);

    // Case 5: run drops with two words buffered and one in flight.
    new_case();
    pkt_len = 16'd10; m_tready = 1'b0; run = 1'b1;
    for (int i = 0; i < 10; i++) push_word(32'h50 + i, i == 9);
    for (int n = 0; n < 20 && rinc_cnt < 3; n++) step();
    check("c5_fill", rinc_cnt, 3);
    run = 1'b0; m_tready = 1'b1;
    repeat (8) step();
    check("c5_beats_stopped", case_beats, 3);
    check("c5_rinc_stopped",  rinc_cnt, 3);
    check("c5_valid_low",     {63'b0, m_tvalid}, 64'd0);
    run = 1'b1;
    drain("c5", 60);
    check("c5_beats", case_beats, 10);
    check("c5_done",  done_cnt, 1);

    // Case 6: reset in the middle of a packet.
    new_case();
    pkt_len = 16'd4;
    for (int i = 0; i < 6; i++) push_word(32'h60 + i, (i % 4) == 3);
    for (int n = 0; n < 20 && case_beats < 1; n++) step();
    check("c6_first_beat", case_beats, 1);
    m_tready = 1'b0;
    step();
    step();
    check("c6_buffered", {63'b0, m_tvalid}, 64'd1);
    rst = 1'b1;
    #1;
    check("c6_rst_valid", {63'b0, m_tvalid}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("c6_valid", {63'b0, m_tvalid}, 64'd0);
    check("c6_state", 64'(dut.state_q), 64'd0);
    check("c6_beat",  64'(dut.beat_q), 64'd0);
    new_case();
    pkt_len = 16'd3; m_tready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(32'h70 + i, i == 2);
    drain("c6", 40);
    check("c6_beats", case_beats, 3);
    check("c6_done",  done_cnt, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
